// File: rtl/cu_pkg.sv
// Shared types and constants for the multicycle control unit: FSM states,
// instruction classes, opcode map, pc_src encodings and ALU control classes.
package cu_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    IC_ALU  = 3'd0,
    IC_LW   = 3'd1,
    IC_SW   = 3'd2,
    IC_BR   = 3'd3,
    IC_JMP  = 3'd4,
    IC_RET  = 3'd5,
    IC_HALT = 3'd6,
    IC_ILL  = 3'd7
  } iclass_t;

  // Opcodes are compared after zero-extension to 32 bits.
  localparam logic [31:0] OP_LW     = 32'h0000_0000;
  localparam logic [31:0] OP_SW     = 32'h0000_0001;
  localparam logic [31:0] OP_ALU_LO = 32'h0000_0002;
  localparam logic [31:0] OP_FN_LO  = 32'h0000_0004;
  localparam logic [31:0] OP_FN_HI  = 32'h0000_000B;
  localparam logic [31:0] OP_ALU_HI = 32'h0000_0013;
  localparam logic [31:0] OP_BRZ    = 32'h0000_0014;
  localparam logic [31:0] OP_BRN    = 32'h0000_0015;
  localparam logic [31:0] OP_BRC    = 32'h0000_0016;
  localparam logic [31:0] OP_BRO    = 32'h0000_0017;
  localparam logic [31:0] OP_BRA    = 32'h0000_0018;
  localparam logic [31:0] OP_JMP    = 32'h0000_0019;
  localparam logic [31:0] OP_RET    = 32'h0000_001A;
  localparam logic [31:0] OP_HALT   = 32'h0000_001B;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;
  localparam logic [1:0] PC_RET = 2'd3;

  localparam logic [1:0] ALU_CLS_PASS = 2'b00;
  localparam logic [1:0] ALU_CLS_BR   = 2'b01;
  localparam logic [1:0] ALU_CLS_ADD  = 2'b10;

  localparam logic [2:0] BR_Z   = 3'd0;
  localparam logic [2:0] BR_N   = 3'd1;
  localparam logic [2:0] BR_C   = 3'd2;
  localparam logic [2:0] BR_O   = 3'd3;
  localparam logic [2:0] BR_ALW = 3'd4;

  function automatic logic branch_taken(input logic [2:0] sel, input logic z,
                                        input logic n, input logic c, input logic o);
    logic t;
    case (sel)
      BR_Z:    t = z;
      BR_N:    t = n;
      BR_C:    t = c;
      BR_O:    t = o;
      BR_ALW:  t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/cu_opcode_decode.sv
// Combinational opcode lookup: instruction class, ALU control class and
// branch condition select.
module cu_opcode_decode
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output iclass_t             iclass,
  output logic [1:0]          alu_class,
  output logic [2:0]          br_sel
);

  logic [31:0] op_ext;
  assign op_ext = 32'(opcode);

  // Classify the opcode against the instruction map.
  always_comb begin
    iclass    = IC_ILL;
    alu_class = ALU_CLS_PASS;
    br_sel    = BR_ALW;
    if (op_ext == OP_LW) begin
      iclass = IC_LW;
    end else if (op_ext == OP_SW) begin
      iclass = IC_SW;
    end else if ((op_ext >= OP_ALU_LO) && (op_ext <= OP_ALU_HI)) begin
      iclass = IC_ALU;
      if ((op_ext >= OP_FN_LO) && (op_ext <= OP_FN_HI)) begin
        alu_class = ALU_CLS_ADD;
      end else begin
        alu_class = ALU_CLS_PASS;
      end
    end else if (op_ext == OP_BRZ) begin
      iclass = IC_BR;
      br_sel = BR_Z;
    end else if (op_ext == OP_BRN) begin
      iclass = IC_BR;
      br_sel = BR_N;
    end else if (op_ext == OP_BRC) begin
      iclass = IC_BR;
      br_sel = BR_C;
    end else if (op_ext == OP_BRO) begin
      iclass = IC_BR;
      br_sel = BR_O;
    end else if (op_ext == OP_BRA) begin
      iclass = IC_BR;
      br_sel = BR_ALW;
    end else if (op_ext == OP_JMP) begin
      iclass = IC_JMP;
    end else if (op_ext == OP_RET) begin
      iclass = IC_RET;
    end else if (op_ext == OP_HALT) begin
      iclass = IC_HALT;
    end else begin
      iclass = IC_ILL;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with retired-instruction counter.
// Optional macro ILLEGAL_TRAP_EN adds the illegal_op output and the TRAP state.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALU_OP_W = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_z,
  input  logic                flag_n,
  input  logic                flag_c,
  input  logic                flag_o,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_load,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                halted,
  output logic [CNT_W-1:0]    retired
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                illegal_op
`endif
);

  state_t      state_r, state_next_s;
  iclass_t     dec_class_s, class_r;
  logic [1:0]  dec_alu_s, alu_r;
  logic [2:0]  dec_br_s, br_r;
  logic [CNT_W-1:0] retired_r;
  logic        retire_s;
  logic        taken_s;

  cu_opcode_decode #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode    (opcode),
    .iclass    (dec_class_s),
    .alu_class (dec_alu_s),
    .br_sel    (dec_br_s)
  );

  assign taken_s = branch_taken(br_r, flag_z, flag_n, flag_c, flag_o);
  assign retired = retired_r;

  // State register, decoded-opcode latch and retired counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= FETCH;
      class_r   <= IC_ILL;
      alu_r     <= ALU_CLS_PASS;
      br_r      <= BR_ALW;
      retired_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_next_s;
      retired_r <= retired_r + CNT_W'(retire_s);
      if (state_r == DECODE) begin
        class_r <= dec_class_s;
        alu_r   <= dec_alu_s;
        br_r    <= dec_br_s;
      end
    end
  end

  // Next state and Moore controls; everything is forced low while rst_n is low.
  always_comb begin
    state_next_s = state_r;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SEQ;
    alu_op       = {ALU_OP_W{1'b0}};
    alu_src      = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    halted       = 1'b0;
    retire_s     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_op   = 1'b0;
`endif
    if (rst_n) begin
      case (state_r)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load      = 1'b1;
            pc_write     = 1'b1;
            pc_src       = PC_SEQ;
            state_next_s = DECODE;
          end else begin
            state_next_s = FETCH;
          end
        end
        DECODE: begin
`ifdef ILLEGAL_TRAP_EN
          state_next_s = (dec_class_s == IC_ILL) ? TRAP : EXEC;
`else
          state_next_s = EXEC;
`endif
        end
        EXEC: begin
          case (class_r)
            IC_ALU: begin
              alu_op       = ALU_OP_W'(alu_r);
              state_next_s = WB;
            end
            IC_LW, IC_SW: begin
              alu_src      = 1'b1;
              alu_op       = ALU_OP_W'(ALU_CLS_ADD);
              state_next_s = MEM;
            end
            IC_BR: begin
              alu_op   = ALU_OP_W'(ALU_CLS_BR);
              retire_s = 1'b1;
              if (taken_s) begin
                pc_write = 1'b1;
                pc_src   = PC_BR;
              end else begin
                pc_write = 1'b0;
              end
              state_next_s = FETCH;
            end
            IC_JMP: begin
              pc_write     = 1'b1;
              pc_src       = PC_JMP;
              retire_s     = 1'b1;
              state_next_s = FETCH;
            end
            IC_RET: begin
              pc_write     = 1'b1;
              pc_src       = PC_RET;
              retire_s     = 1'b1;
              state_next_s = FETCH;
            end
            IC_HALT: begin
              retire_s     = 1'b1;
              state_next_s = HALT;
            end
            default: begin
              // Illegal opcode retires as a NOP.
              retire_s     = 1'b1;
              state_next_s = FETCH;
            end
          endcase
        end
        MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (class_r == IC_SW);
          if (mem_ready) begin
            if (class_r == IC_SW) begin
              retire_s     = 1'b1;
              state_next_s = FETCH;
            end else begin
              state_next_s = WB;
            end
          end else begin
            state_next_s = MEM;
          end
        end
        WB: begin
          reg_write    = 1'b1;
          retire_s     = 1'b1;
          state_next_s = FETCH;
          if (class_r == IC_LW) begin
            mem_to_reg = 1'b1;
          end else begin
            reg_dst = 1'b1;
          end
        end
        HALT: begin
          halted       = 1'b1;
          state_next_s = HALT;
        end
        TRAP: begin
`ifdef ILLEGAL_TRAP_EN
          illegal_op = 1'b1;
          pc_write   = 1'b1;
          pc_src     = PC_JMP;
`endif
          state_next_s = FETCH;
        end
        default: begin
          state_next_s = FETCH;
        end
      endcase
    end else begin
      state_next_s = FETCH;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-cycle expected control vectors built from the
// instruction-level timing rules, with randomized opcodes, flags and wait states.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       flag_z, flag_n, flag_c, flag_o;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_load, pc_write;
  logic [1:0] pc_src;
  logic [1:0] alu_op;
  logic       alu_src, reg_dst, mem_to_reg, reg_write, halted;
  logic [3:0] retired;
  logic       illegal_op_s;

  multicycle_control_unit #(.OPCODE_W(6), .ALU_OP_W(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_o(flag_o),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src(alu_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .halted(halted), .retired(retired)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op_s)
`endif
  );

`ifndef ILLEGAL_TRAP_EN
  assign illegal_op_s = 1'b0;
`endif

  always #5 clk = ~clk;

  localparam logic [14:0] B_ILL  = 15'h4000;
  localparam logic [14:0] B_REQ  = 15'h2000;
  localparam logic [14:0] B_WE   = 15'h1000;
  localparam logic [14:0] B_IORD = 15'h0800;
  localparam logic [14:0] B_IRL  = 15'h0400;
  localparam logic [14:0] B_PCW  = 15'h0200;
  localparam logic [14:0] B_SRC  = 15'h0010;
  localparam logic [14:0] B_RDST = 15'h0008;
  localparam logic [14:0] B_M2R  = 15'h0004;
  localparam logic [14:0] B_RW   = 15'h0002;
  localparam logic [14:0] B_HALT = 15'h0001;

  logic [14:0] obs;
  assign obs = {illegal_op_s, mem_req, mem_we, iord, ir_load, pc_write, pc_src,
                alu_op, alu_src, reg_dst, mem_to_reg, reg_write, halted};

  int n_checks = 0;
  int n_pass = 0;
  logic [3:0] exp_ret = 4'd0;

  function automatic logic [14:0] f_pc(input int v);
    return 15'(v) << 7;
  endfunction

  function automatic logic [14:0] f_alu(input int v);
    return 15'(v) << 5;
  endfunction

  // One clock cycle: inputs are already set; compare at the falling edge.
  task automatic cyc(input logic [14:0] exp, input string tag, input bit last);
    @(negedge clk);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: controls %h expected %h", tag, obs, exp);
    end
    n_checks++;
    assert (retired === exp_ret) begin
      n_pass++;
    end else begin
      $error("FAIL %s_retired: retired %0d expected %0d", tag, retired, exp_ret);
    end
    if (last) exp_ret = exp_ret + 4'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int fw);
    for (int i = 0; i < fw; i++) begin
      mem_ready = 1'b0;
      cyc(B_REQ, "fetch_wait", 1'b0);
    end
    mem_ready = 1'b1;
    cyc(B_REQ | B_IRL | B_PCW, "fetch", 1'b0);
  endtask

  // Reference: expected cycle sequence of one instruction from the opcode map.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input logic [3:0] fl);
    logic [14:0] mem_v;
    bit taken;
    opcode = op;
    fetch(fw);
    mem_ready = 1'($urandom);
    cyc(15'h0, "decode", 1'b0);
    opcode = 6'($urandom);
    {flag_o, flag_c, flag_n, flag_z} = fl;
    mem_ready = 1'($urandom);
    if (op == 6'h00 || op == 6'h01) begin
      cyc(f_alu(2) | B_SRC, "exec_mem", 1'b0);
      mem_v = B_REQ | B_IORD | ((op == 6'h01) ? B_WE : 15'h0);
      for (int i = 0; i < mw; i++) begin
        mem_ready = 1'b0;
        cyc(mem_v, "mem_wait", 1'b0);
      end
      mem_ready = 1'b1;
      cyc(mem_v, "mem", op == 6'h01);
      if (op == 6'h00) begin
        mem_ready = 1'($urandom);
        cyc(B_RW | B_M2R, "wb_lw", 1'b1);
      end
    end else if (op <= 6'h13) begin
      cyc(f_alu((op >= 6'h04 && op <= 6'h0B) ? 2 : 0), "exec_alu", 1'b0);
      mem_ready = 1'($urandom);
      cyc(B_RW | B_RDST, "wb_alu", 1'b1);
    end else if (op <= 6'h18) begin
      taken = (op == 6'h18) ? 1'b1 : fl[op - 6'h14];
      cyc(f_alu(1) | (taken ? (B_PCW | f_pc(1)) : 15'h0), "exec_br", 1'b1);
    end else if (op == 6'h19) begin
      cyc(B_PCW | f_pc(2), "exec_jmp", 1'b1);
    end else if (op == 6'h1A) begin
      cyc(B_PCW | f_pc(3), "exec_ret", 1'b1);
    end else if (op == 6'h1B) begin
      cyc(15'h0, "exec_halt", 1'b1);
    end else begin
`ifdef ILLEGAL_TRAP_EN
      cyc(B_ILL | B_PCW | f_pc(2), "trap", 1'b0);
`else
      cyc(15'h0, "exec_illegal", 1'b1);
`endif
    end
  endtask

  initial begin
    logic [5:0] rop;
    rst_n = 1'b0;
    opcode = 6'h00;
    {flag_o, flag_c, flag_n, flag_z} = 4'h0;
    mem_ready = 1'b1;
    cyc(15'h0, "reset", 1'b0);
    rst_n = 1'b1;

    // Directed instruction mix, including alu_op and opcode-range boundaries.
    run_instr(6'h05, 0, 0, 4'h0);
    run_instr(6'h00, 2, 3, 4'h0);
    run_instr(6'h01, 0, 1, 4'h0);
    run_instr(6'h14, 0, 0, 4'h1);
    run_instr(6'h14, 1, 0, 4'hE);
    run_instr(6'h15, 0, 0, 4'h2);
    run_instr(6'h17, 0, 0, 4'h7);
    run_instr(6'h18, 0, 0, 4'h0);
    run_instr(6'h19, 0, 0, 4'h0);
    run_instr(6'h1A, 0, 0, 4'h0);
    run_instr(6'h3F, 0, 0, 4'h0);
    run_instr(6'h1C, 0, 0, 4'h0);
    run_instr(6'h0B, 0, 0, 4'h0);
    run_instr(6'h0C, 0, 0, 4'h0);
    run_instr(6'h13, 0, 0, 4'h0);
    run_instr(6'h03, 0, 0, 4'h0);

    // Randomized program without HALT.
    for (int k = 0; k < 40; k++) begin
      rop = 6'($urandom_range(0, 63));
      if (rop == 6'h1B) rop = 6'h02;
      run_instr(rop, $urandom_range(0, 2), $urandom_range(0, 2), 4'($urandom));
    end

    // Reset in the middle of an LW data access.
    opcode = 6'h00;
    fetch(0);
    mem_ready = 1'b0;
    cyc(15'h0, "decode_lw", 1'b0);
    cyc(f_alu(2) | B_SRC, "exec_lw", 1'b0);
    cyc(B_REQ | B_IORD, "mem_wait_lw", 1'b0);
    rst_n = 1'b0;
    exp_ret = 4'd0;
    cyc(15'h0, "reset_mid_mem", 1'b0);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    cyc(B_REQ, "fetch_after_reset", 1'b0);

    // Seventeen ALU instructions wrap the 4-bit counter to 1.
    for (int k = 0; k < 17; k++) begin
      run_instr(6'h02, 0, 0, 4'($urandom));
    end
    n_checks++;
    assert (retired === 4'd1) begin
      n_pass++;
    end else begin
      $error("FAIL counter_wrap: retired %0d expected 1", retired);
    end

    // HALT sticks until reset and retires exactly once.
    run_instr(6'h1B, 1, 0, 4'h0);
    for (int k = 0; k < 20; k++) begin
      mem_ready = 1'($urandom);
      cyc(B_HALT, "halted", 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Sequential successor to the single-cycle opcode decoder. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with a ready-based memory handshake, resolves conditional branches from datapath flags, and drives registered datapath controls. Sits between the instruction register and the datapath/memory interface. Also counts retired instructions.

Parameters:
OPCODE_W, 6, opcode width; opcodes at or above 2**OPCODE_W are not reachable.
ALU_OP_W, 2, width of alu_op to the ALU control.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
opcode  in  OPCODE_W  IR opcode field; valid from DECODE onward.
flag_z, flag_n, flag_c, flag_o  in  1 each  datapath status flags; sampled in EXEC.
mem_ready  in  1  memory done; valid only while mem_req=1.
mem_req  out  1  memory access request.
mem_we  out  1  1 = write (SW data phase).
iord  out  1  0 = address from PC (fetch), 1 = address from ALU result.
ir_load  out  1  load IR from memory data.
pc_write  out  1  update PC this cycle.
pc_src  out  2  0 = PC+1, 1 = branch target, 2 = jump target, 3 = return register.
alu_op  out  ALU_OP_W  ALU control class.
alu_src  out  1  1 = immediate operand.
reg_dst  out  1  1 = rd, 0 = rt.
mem_to_reg  out  1  1 = write-back from memory data.
reg_write  out  1  register file write enable.
halted  out  1  core stopped.
retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, rst_n=0): state=FETCH; all control outputs 0; halted=0; retired=0. Takes effect immediately, including mid-access. mem_req drops in the same cycle.
- Opcode map:
  - 0x00 LW, 0x01 SW.
  - 0x02–0x13 ALU. alu_op=00 for 0x02, 0x03, 0x0C–0x13; alu_op=10 for 0x04–0x0B.
  - 0x14 BRZ, 0x15 BRN, 0x16 BRC, 0x17 BRO, 0x18 BRA (unconditional).
  - 0x19 JMP, 0x1A RET, 0x1B HALT. All other opcodes are illegal.
- FETCH:
  - Outputs: mem_req=1, iord=0, mem_we=0.
  - Stays in FETCH while mem_ready=0.
  - On mem_ready=1: ir_load=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE: one cycle, no side effects. Next state is EXEC for every legal opcode.
- EXEC:
  - ALU: alu_src=0, alu_op per map; go to WB.
  - LW/SW: alu_src=1, alu_op=10 (address add); go to MEM.
  - Branch: alu_op=01. Taken = flag selected by opcode, or always for BRA. If taken: pc_write=1, pc_src=1. Go to FETCH.
  - JMP: pc_write=1, pc_src=2. RET: pc_write=1, pc_src=3. Both go to FETCH.
  - HALT: go to HALT.
- MEM:
  - Outputs: mem_req=1, iord=1, mem_we=1 for SW.
  - Stays in MEM while mem_ready=0.
  - On ready: SW goes to FETCH; LW goes to WB.
- WB: reg_write=1 for one cycle. reg_dst=1 for ALU; reg_dst=0 and mem_to_reg=1 for LW. Go to FETCH.
- HALT: halted=1; all enables 0. Left only by reset.
- Latency (zero memory wait states): ALU 4 cycles; LW 5; SW 4; branch/JMP/RET 3.
- Control outputs are Moore outputs of the registered state and latched opcode. The opcode is latched in DECODE, so later opcode input changes are ignored.
- Retired counter:
  - Increments by 1 on the final cycle of each instruction: WB, SW's MEM-ready cycle, branch/JMP/RET EXEC, and HALT entry.
  - Wraps from 2**CNT_W-1 to 0.
  - Not-taken branches count.
- mem_ready while mem_req=0: ignored.
- Illegal opcode: treated as a 3-cycle NOP (FETCH, DECODE, EXEC, then FETCH); it counts as retired.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined:
  - Adds output illegal_op (1 bit). An illegal opcode in DECODE moves to state TRAP.
  - TRAP: illegal_op=1, pc_write=1, pc_src=2 (trap vector supplied by the datapath on the jump-target input) for one cycle, then FETCH.
  - Not counted in retired.
- Undefined: illegal opcodes behave as a NOP; no illegal_op port.

Decomposition:
- Shared package cu_pkg holds:
  - state enum: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP;
  - opcode constants (OP_LW through OP_HALT);
  - pc_src encodings (PC_SEQ, PC_BR, PC_JMP, PC_RET);
  - alu_op class constants.
- One sub-module, cu_opcode_decode: combinational opcode → instruction-class and alu_op lookup, reused by the FSM. The counter stays inline.

Test Plan:
- Reset mid-MEM (LW with mem_ready=0, assert rst_n=0) → same cycle: mem_req=0, all controls 0, retired=0. After release: FETCH with mem_req=1.
- ALU opcode 0x05 with mem_ready=1 always → reg_write pulses exactly on cycle 4 with reg_dst=1, alu_op=10; retired goes 0→1.
- LW with 2 fetch wait cycles and 3 data wait cycles → reg_write with mem_to_reg=1 on cycle 10; iord=1 only during MEM.
- BRZ with flag_z=1 → pc_write=1, pc_src=1 in EXEC. BRZ with flag_z=0 → no pc_write in EXEC. Both retire in 3 cycles.
- HALT → halted=1 stays high, mem_req=0 for 20 cycles; retired is incremented once.
- CNT_W=4: run 17 NOP-class ALU instructions → retired reads 1 (wrap). With ILLEGAL_TRAP_EN: opcode 0x3F → illegal_op pulse, pc_src=2, retired unchanged.
